muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 178 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// EX-stage controller for an iterative mul/div unit: issues one request at a
// time, drains killed requests, and short-circuits repeats via a one-entry cache.
module muldiv_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_muldiv,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_op32,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            ex_stall,
  output logic            mdu_valid,
  input  logic            mdu_ready,
  output logic [2:0]      mdu_funct3,
  output logic            mdu_is_op32,
  output logic [XLEN-1:0] mdu_op1,
  output logic [XLEN-1:0] mdu_op2,
  input  logic            mdu_rvalid,
  input  logic [XLEN-1:0] mdu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned F3W = 3;
  localparam int unsigned RDW = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              mdu_valid_q, mdu_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic [F3W-1:0]    f3_q, f3_d;
  logic              op32_q, op32_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [RDW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              c_valid_q, c_valid_d;
  logic [F3W-1:0]    c_f3_q, c_f3_d;
  logic              c_op32_q, c_op32_d;
  logic [XLEN-1:0]   c_op1_q, c_op1_d;
  logic [XLEN-1:0]   c_op2_q, c_op2_d;
  logic [XLEN-1:0]   c_data_q, c_data_d;
  logic              accept;
  logic              cache_hit;

  // Tags compare at full width, so W-forms with differing upper bits miss.
  assign cache_hit = c_valid_q && (c_f3_q == ex_funct3) && (c_op32_q == ex_is_op32)
                     && (c_op1_q == ex_op1) && (c_op2_q == ex_op2);
  assign accept    = ex_valid && ex_is_muldiv && !flush;

  always_comb begin
    state_d     = state_q;
    mdu_valid_d = 1'b0;
    wb_valid_d  = 1'b0;
    f3_d        = f3_q;
    op32_d      = op32_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    data_d      = data_q;
    c_valid_d   = c_valid_q;
    c_f3_d      = c_f3_q;
    c_op32_d    = c_op32_q;
    c_op1_d     = c_op1_q;
    c_op2_d     = c_op2_q;
    c_data_d    = c_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d = ex_rd;
          if (cache_hit) begin
            data_d  = c_data_q;
            state_d = DONE;
          end else begin
            f3_d    = ex_funct3;
            op32_d  = ex_is_op32;
            op1_d   = ex_op1;
            op2_d   = ex_op2;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A handshake already taken must be drained even if killed this cycle.
        if (mdu_ready) state_d = flush ? DRAIN : WAIT;
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        if (flush) begin
          state_d = mdu_rvalid ? IDLE : DRAIN;
        end else if (mdu_rvalid) begin
          data_d    = mdu_result;
          c_valid_d = 1'b1;
          c_f3_d    = f3_q;
          c_op32_d  = op32_q;
          c_op1_d   = op1_q;
          c_op2_d   = op2_q;
          c_data_d  = mdu_result;
          state_d   = DONE;
        end
      end
      DRAIN: begin
        if (mdu_rvalid) state_d = IDLE;
      end
      DONE: begin
        if (wb_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mdu_valid_d = (state_d == ISSUE);
    wb_valid_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mdu_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      f3_q        <= '0;
      op32_q      <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      c_valid_q   <= 1'b0;
      c_f3_q      <= '0;
      c_op32_q    <= 1'b0;
      c_op1_q     <= '0;
      c_op2_q     <= '0;
      c_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      mdu_valid_q <= mdu_valid_d;
      wb_valid_q  <= wb_valid_d;
      f3_q        <= f3_d;
      op32_q      <= op32_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      c_valid_q   <= c_valid_d;
      c_f3_q      <= c_f3_d;
      c_op32_q    <= c_op32_d;
      c_op1_q     <= c_op1_d;
      c_op2_q     <= c_op2_d;
      c_data_q    <= c_data_d;
    end
  end

  // DRAIN holds any muldiv in EX regardless of flush so it cannot issue early.
  assign ex_stall = ex_valid && ex_is_muldiv &&
                    ((state_q == DRAIN) ||
                     (!((state_q == DONE) && wb_ready) && !flush));

  assign mdu_valid   = mdu_valid_q;
  assign mdu_funct3  = f3_q;
  assign mdu_is_op32 = op32_q;
  assign mdu_op1     = op1_q;
  assign mdu_op2     = op2_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = rd_q;
  assign wb_data     = data_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed scenarios plus random ops checked against an
// arithmetic RV64M reference, with a behavioural mul/div unit on the other side.
`timescale 1ns/1ps
module tb_muldiv_ctrl;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_is_muldiv, ex_is_op32, flush;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_op1, ex_op2;
  logic [4:0]      ex_rd;
  logic            ex_stall, mdu_valid, mdu_ready, mdu_is_op32, mdu_rvalid;
  logic [2:0]      mdu_funct3;
  logic [XLEN-1:0] mdu_op1, mdu_op2, mdu_result;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_muldiv(ex_is_muldiv),
    .ex_funct3(ex_funct3), .ex_is_op32(ex_is_op32), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd(ex_rd), .flush(flush), .ex_stall(ex_stall), .mdu_valid(mdu_valid),
    .mdu_ready(mdu_ready), .mdu_funct3(mdu_funct3), .mdu_is_op32(mdu_is_op32),
    .mdu_op1(mdu_op1), .mdu_op2(mdu_op2), .mdu_rvalid(mdu_rvalid),
    .mdu_result(mdu_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // RV64M result for full-width operands.
  function automatic logic [XLEN-1:0] rv_ref64(input logic [2:0] f3,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    logic [XLEN-1:0] min_v, ones;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    min_v = {1'b1, 63'd0};
    ones = '1;
    case (f3)
      3'd0: begin p = sa * sb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 64'd0) return ones;
        if (a == min_v && b == ones) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 64'd0) ? ones : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == min_v && b == ones) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // W-forms: extend the low words, compute at 64 bits, sign-extend the low word.
  function automatic logic [XLEN-1:0] rv_ref(input logic [2:0] f3, input logic op32,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] ea, eb, r;
    if (!op32) return rv_ref64(f3, a, b);
    if (f3 == 3'd5 || f3 == 3'd7) begin
      ea = {32'd0, a[31:0]};
      eb = {32'd0, b[31:0]};
    end else begin
      ea = {{32{a[31]}}, a[31:0]};
      eb = {{32{b[31]}}, b[31:0]};
    end
    r = rv_ref64(f3, ea, eb);
    return {{32{r[31]}}, r[31:0]};
  endfunction

  // Behavioural unit: accepts when idle, answers after unit_lat cycles.
  logic            unit_busy, unit_hold;
  int              unit_cnt, unit_lat;
  int              hs_cnt = 0;
  logic [XLEN-1:0] unit_res;
  assign mdu_ready = !unit_busy && !unit_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_busy  <= 1'b0;
      unit_cnt   <= 0;
      unit_res   <= '0;
      mdu_rvalid <= 1'b0;
      mdu_result <= '0;
    end else begin
      mdu_rvalid <= 1'b0;
      if (unit_busy) begin
        if (unit_cnt <= 1) begin
          unit_busy  <= 1'b0;
          mdu_rvalid <= 1'b1;
          mdu_result <= unit_res;
        end else begin
          unit_cnt <= unit_cnt - 1;
        end
      end
      if (mdu_valid && mdu_ready) begin
        unit_busy <= 1'b1;
        unit_cnt  <= unit_lat;
        unit_res  <= rv_ref(mdu_funct3, mdu_is_op32, mdu_op1, mdu_op2);
        hs_cnt    <= hs_cnt + 1;
      end
    end
  end

  // Reference cache: the last operation that completed without a flush.
  logic            mc_valid = 1'b0;
  logic [2:0]      mc_f3;
  logic            mc_op32;
  logic [XLEN-1:0] mc_a, mc_b;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic op32, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_muldiv = 1'b1; ex_funct3 = f3; ex_is_op32 = op32;
    ex_op1 = a; ex_op2 = b; ex_rd = rd;
  endtask

  // One op to retirement, with wb_ready held low for 'hold' cycles in DONE.
  task automatic run_op(input logic [2:0] f3, input logic op32, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [4:0] rd, input int hold);
    bit hit, seen_mv;
    logic [XLEN-1:0] exp;
    int hs0, n;
    hit = mc_valid && mc_f3 == f3 && mc_op32 == op32 && mc_a == a && mc_b == b;
    exp = rv_ref(f3, op32, a, b);
    hs0 = hs_cnt;
    drive(f3, op32, a, b, rd);
    wb_ready = 1'b0; flush = 1'b0;
    #1;
    chk("stall_accept", 64'(ex_stall), 64'd1);
    n = 0; seen_mv = 0;
    do begin
      step(); n++;
      if (mdu_valid) seen_mv = 1;
    end while (!wb_valid && n < 60);
    chk("wb_valid_reached", 64'(wb_valid), 64'd1);
    if (hit) begin
      chk("hit_latency", 64'(n), 64'd1);
      chk("hit_no_mdu_valid", 64'(seen_mv), 64'd0);
    end
    chk("handshakes", 64'(hs_cnt - hs0), hit ? 64'd0 : 64'd1);
    chk("wb_rd", 64'(wb_rd), 64'(rd));
    chk("wb_data", wb_data, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_wb_valid", 64'(wb_valid), 64'd1);
      chk("hold_wb_data", wb_data, exp);
      chk("hold_ex_stall", 64'(ex_stall), 64'd1);
    end
    wb_ready = 1'b1;
    #1;
    chk("retire_stall", 64'(ex_stall), 64'd0);
    step();
    ex_valid = 1'b0; wb_ready = 1'b0;
    chk("wb_valid_drop", 64'(wb_valid), 64'd0);
    mc_valid = 1'b1; mc_f3 = f3; mc_op32 = op32; mc_a = a; mc_b = b;
  endtask

  // Miss killed in WAIT; MUL 3*3 waits in EX behind it.
  task automatic flush_op(input logic [2:0] f3, input logic op32, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [4:0] rd, input bit coincide);
    int hs0, n;
    hs0 = hs_cnt;
    drive(f3, op32, a, b, rd);
    wb_ready = 1'b0; flush = 1'b0;
    n = 0;
    do begin step(); n++; end while (hs_cnt == hs0 && n < 60);
    chk("flush_op_issued", 64'(hs_cnt - hs0), 64'd1);
    if (coincide) begin
      n = 0;
      while (!mdu_rvalid && n < 60) begin step(); n++; end
      chk("coincide_rvalid", 64'(mdu_rvalid), 64'd1);
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(ex_stall), 64'd0);
    step();
    flush = 1'b0;
    drive(3'd0, 1'b0, 64'd3, 64'd3, 5'd9);
    #1;
    if (!coincide) begin
      chk("drain_stall", 64'(ex_stall), 64'd1);
      n = 0;
      while (!mdu_rvalid && n < 60) begin
        chk("drain_mdu_valid", 64'(mdu_valid), 64'd0);
        chk("drain_wb_valid", 64'(wb_valid), 64'd0);
        step(); n++;
      end
      chk("drain_rvalid", 64'(mdu_rvalid), 64'd1);
      step();
    end
    chk("flush_no_wb", 64'(wb_valid), 64'd0);
    chk("flush_no_reissue", 64'(mdu_valid), 64'd0);
    chk("flush_one_hs", 64'(hs_cnt - hs0), 64'd1);
  endtask

  initial begin
    logic [2:0] f3, pf3;
    logic op32, pop32;
    logic [XLEN-1:0] a, b, pa, pb;
    int hs0;

    rst = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0; ex_funct3 = '0; ex_is_op32 = 1'b0;
    ex_op1 = '0; ex_op2 = '0; ex_rd = '0; flush = 1'b0; wb_ready = 1'b0;
    unit_lat = 2; unit_hold = 1'b0;
    pf3 = '0; pop32 = 1'b0; pa = '0; pb = '0;
    step(); step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mdu_valid", 64'(mdu_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_mdu_op1", mdu_op1, 64'd0);
    chk("rst_ex_stall", 64'(ex_stall), 64'd0);
    rst = 1'b1;
    step();

    run_op(3'd0, 1'b0, 64'd7, 64'd6, 5'd5, 0);
    run_op(3'd0, 1'b0, 64'd7, 64'd6, 5'd5, 0);
    run_op(3'd4, 1'b0, 64'd100, 64'd0, 5'd3, 0);
    run_op(3'd4, 1'b0, 64'd100, 64'd0, 5'd3, 0);

    unit_lat = 6;
    flush_op(3'd5, 1'b0, 64'd1000, 64'd7, 5'd4, 1'b0);
    run_op(3'd0, 1'b0, 64'd3, 64'd3, 5'd9, 0);
    run_op(3'd5, 1'b0, 64'd1000, 64'd7, 5'd4, 0);
    run_op(3'd3, 1'b0, '1, '1, 5'd8, 5);

    unit_lat = 1;
    flush_op(3'd6, 1'b0, -64'sd17, 64'd5, 5'd2, 1'b1);
    run_op(3'd0, 1'b0, 64'd3, 64'd3, 5'd9, 0);

    // Killed while ISSUE is still waiting on the unit: no request may escape.
    unit_hold = 1'b1;
    hs0 = hs_cnt;
    drive(3'd7, 1'b0, 64'd77, 64'd10, 5'd6);
    step();
    chk("issue_mdu_valid", 64'(mdu_valid), 64'd1);
    chk("issue_mdu_op1", mdu_op1, 64'd77);
    chk("issue_mdu_funct3", 64'(mdu_funct3), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0; ex_valid = 1'b0; unit_hold = 1'b0;
    chk("issue_flush_mdu_valid", 64'(mdu_valid), 64'd0);
    step(); step();
    chk("issue_flush_no_hs", 64'(hs_cnt - hs0), 64'd0);
    chk("issue_flush_no_wb", 64'(wb_valid), 64'd0);

    run_op(3'd4, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 5'd10, 1);
    run_op(3'd0, 1'b1, 64'h1_0000_0005, 64'd3, 5'd11, 0);
    run_op(3'd0, 1'b1, 64'h2_0000_0005, 64'd3, 5'd11, 0);

    // Reset while the unit is busy with a fresh miss.
    run_op(3'd5, 1'b0, 64'd55, 64'd5, 5'd12, 0);
    unit_lat = 8;
    hs0 = hs_cnt;
    drive(3'd0, 1'b0, 64'd11, 64'd13, 5'd13);
    for (int i = 0; i < 4; i++) step();
    chk("rst_test_issued", 64'(hs_cnt - hs0), 64'd1);
    rst = 1'b0;
    ex_valid = 1'b0;
    #1;
    chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
    chk("midrst_mdu_valid", 64'(mdu_valid), 64'd0);
    chk("midrst_wb_data", wb_data, 64'd0);
    chk("midrst_mdu_op1", mdu_op1, 64'd0);
    chk("midrst_ex_stall", 64'(ex_stall), 64'd0);
    step();
    rst = 1'b1;
    mc_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wb_valid || mdu_rvalid) break;
    end
    chk("postrst_no_wb", 64'(wb_valid), 64'd0);
    chk("postrst_no_rvalid", 64'(mdu_rvalid), 64'd0);
    unit_lat = 2;
    run_op(3'd5, 1'b0, 64'd55, 64'd5, 5'd12, 0);
    run_op(3'd0, 1'b0, 64'd11, 64'd13, 5'd13, 0);

    for (int k = 0; k < 50; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        f3 = pf3; op32 = pop32; a = pa; b = pb;
      end else begin
        f3 = 3'($urandom_range(0, 7));
        op32 = 1'($urandom_range(0, 1));
        if (op32 && f3 >= 3'd1 && f3 <= 3'd3) f3 = 3'd0;
        case ($urandom_range(0, 4))
          0: a = '0;
          1: a = '1;
          2: a = {1'b1, 63'd0};
          3: a = 64'($urandom_range(0, 50));
          default: a = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 4))
          0: b = '0;
          1: b = '1;
          2: b = 64'hFFFF_FFFF;
          3: b = 64'($urandom_range(0, 50));
          default: b = {$urandom, $urandom};
        endcase
      end
      unit_lat = $urandom_range(1, 5);
      run_op(f3, op32, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
      pf3 = f3; pop32 = op32; pa = a; pb = b;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
